// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio datapath.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT
  } rx_state_t;

  typedef struct packed {
    logic        left;
    logic [15:0] data;
  } sample_t;

  // I2S puts the MSB one bit clock after the LRCK transition.
  localparam int I2S_DELAY_BITS = 1;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module sample_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Storage and pointers; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S capture from the codec ADC: synchronize the serial link into clk,
// deserialize MSB-first words per channel and queue them for the consumer.
module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear_status,
  input  logic                  adc_bclk,
  input  logic                  adc_lrck,
  input  logic                  adc_dat,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_left,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [1:0]            bclk_sync, lrck_sync, dat_sync;
  logic                  bclk_dly, lrck_prev;
  logic                  bclk_rise, lrck, dat, lrck_edge;
  rx_state_t             state, state_n;
  logic                  start, shift_en, push, ferr_set;
  logic [CW-1:0]         bitcnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  chan;
  logic                  fifo_full, fifo_empty, ovf_set;
  logic [DATA_WIDTH:0]   fifo_rdata;

  // Two-flop synchronizers plus one extra BCLK stage for rise detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_dly  <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], adc_bclk};
      lrck_sync <= {lrck_sync[0], adc_lrck};
      dat_sync  <= {dat_sync[0], adc_dat};
      bclk_dly  <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] && !bclk_dly;
  assign lrck      = lrck_sync[1];
  assign dat       = dat_sync[1];
  assign lrck_edge = bclk_rise && (lrck != lrck_prev);

  // LRCK as seen at the previous bit-clock rise; tracked even while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       lrck_prev <= 1'b0;
    else if (bclk_rise) lrck_prev <= lrck;
  end

  // Capture state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state and datapath controls. The bit at an LRCK edge is the
  // I2S delay slot, so a new word starts counting from the following rise.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (lrck_edge) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
        SHIFT: begin
          if (bitcnt == CW'(DATA_WIDTH)) begin
            push    = 1'b1;
            state_n = WAIT;
          end else if (lrck_edge) begin
            start    = 1'b1;
            ferr_set = 1'b1;
          end else if (bclk_rise) begin
            shift_en = 1'b1;
          end
        end
        WAIT: if (lrck_edge) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and channel tag for the word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      chan   <= 1'b0;
    end else if (start) begin
      chan   <= !lrck;
      bitcnt <= '0;
    end else if (shift_en) begin
      shreg  <= {shreg[DATA_WIDTH-2:0], dat};
      bitcnt <= bitcnt + CW'(1);
    end
  end

  sample_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({chan, shreg}),
    .pop     (sample_ready),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rdata   (fifo_rdata)
  );

  assign sample_valid = !fifo_empty;
  assign sample_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign sample_left  = fifo_rdata[DATA_WIDTH];
  assign ovf_set      = push && fifo_full && !(sample_ready && !fifo_empty);

  // Sticky status; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      overflow    <= ovf_set  || (overflow    && !clear_status);
      frame_error <= ferr_set || (frame_error && !clear_status);
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench: I2S codec BFM at BCLK = clk/4 with 32-bit slots, a pop monitor,
// and a queue model of which complete slots should come out of the FIFO.
module tb_i2s_adc_receiver;
  import audio_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, enable, clear_status;
  logic        adc_bclk, adc_lrck, adc_dat;
  logic [15:0] sample_data;
  logic        sample_left, sample_valid, sample_ready;
  logic        overflow, frame_error;

  int      errors = 0;
  int      checks = 0;
  int      gb;
  int      held;
  bit      hold;
  bit      exp_ovf;
  sample_t got[$];
  sample_t exp_q[$];

  i2s_adc_receiver #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear_status (clear_status),
    .adc_bclk     (adc_bclk),
    .adc_lrck     (adc_lrck),
    .adc_dat      (adc_dat),
    .sample_data  (sample_data),
    .sample_left  (sample_left),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  // Record every pop; ready only changes just after posedge, so this is stable.
  always @(negedge clk)
    if (sample_valid && sample_ready) got.push_back({sample_left, sample_data});

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Expected FIFO content: consumer keeps up unless holding; when held full, drop.
  task automatic model_push(input logic left, input logic [15:0] d, input bit pop_now);
    if (!hold) exp_q.push_back({left, d});
    else begin
      if (pop_now) held--;
      if (held < DEPTH) begin
        exp_q.push_back({left, d});
        held++;
      end else exp_ovf = 1'b1;
    end
  endtask

  task automatic begin_test(input logic rdy);
    @(posedge clk); #1;
    sample_ready = rdy;
    hold    = !rdy;
    held    = 0;
    exp_ovf = 1'b0;
    exp_q.delete();
    gb = got.size();
  endtask

  task automatic drain();
    @(posedge clk); #1 sample_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 sample_ready = 1'b0;
    held = 0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_status = 1'b1;
    @(posedge clk); #1 clear_status = 1'b0;
  endtask

  // One I2S slot: delay bit, 16 data bits MSB first, random padding.
  // mode 1 checks push latency on the final data bit; mode 2 pops exactly
  // in the cycle the final data bit is pushed.
  task automatic send_slot(input logic lr, input logic [15:0] d, input int nbits,
                           input int mode, input int en_bit, input logic en_val);
    logic b;
    int   j;
    for (int i = 0; i < nbits; i++) begin
      j = i - I2S_DELAY_BITS;
      b = (j >= 0 && j < 16) ? d[15-j] : 1'($urandom);
      if (i == en_bit) enable = en_val;
      @(negedge clk); adc_bclk = 1'b0; adc_lrck = lr; adc_dat = b;
      @(negedge clk);
      @(negedge clk); adc_bclk = 1'b1;
      if (j == 15 && mode == 1) begin
        repeat (3) @(posedge clk);
        #1 checks++;
        if (sample_valid !== 1'b0) begin
          errors++; $display("FAIL latency_early valid=%b exp=0", sample_valid);
        end
        @(posedge clk);
        #1 checks++;
        if (sample_valid !== 1'b1) begin
          errors++; $display("FAIL latency_push valid=%b exp=1", sample_valid);
        end
      end else if (j == 15 && mode == 2) begin
        repeat (3) @(posedge clk);
        #1 sample_ready = 1'b1;
        @(posedge clk);
        #1 sample_ready = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic prime();
    enable = 1'b0;
    send_slot(1'b1, 16'h0, 4, 0, -1, 1'b0);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    if (sample_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", sample_data); end
    if (sample_left !== 1'b0) begin errors++; $display("FAIL reset_left got=%b exp=0", sample_left); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [15:0] a, c;
    a = 16'($urandom); c = 16'($urandom);
    prime();
    begin_test(1'b0);
    send_slot(1'b0, a, 32, 1, -1, 1'b0); model_push(1'b1, a, 0);
    send_slot(1'b1, c, 32, 0, -1, 1'b0); model_push(1'b0, c, 0);
    drain();
    checks++;
    if (got.size() - gb !== exp_q.size()) begin
      errors++; $display("FAIL latency_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL latency_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_basic();
    begin_test(1'b1);
    send_slot(1'b0, 16'h8001, 32, 0, -1, 1'b0); model_push(1'b1, 16'h8001, 0);
    send_slot(1'b1, 16'h7FFE, 32, 0, -1, 1'b0); model_push(1'b0, 16'h7FFE, 0);
    repeat (4) @(posedge clk);
    #1 sample_ready = 1'b0;
    checks += 3;
    if (got.size() - gb !== 2) begin errors++; $display("FAIL basic_count got=%0d exp=2", got.size() - gb); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", frame_error); end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    begin_test(1'b0);
    for (int k = 0; k < 6; k++) begin
      d = 16'($urandom);
      send_slot(k[0], d, 32, 0, -1, 1'b0);
      model_push(!k[0], d, 0);
    end
    checks += 2;
    if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf); end
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", sample_valid); end
    drain();
    checks++;
    if (got.size() - gb !== exp_q.size()) begin
      errors++; $display("FAIL ovf_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
    pulse_clear();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_short_frame();
    begin_test(1'b1);
    send_slot(1'b0, 16'($urandom), 11, 0, -1, 1'b0);
    send_slot(1'b1, 16'h1234, 32, 0, -1, 1'b0); model_push(1'b0, 16'h1234, 0);
    #1 sample_ready = 1'b0;
    checks += 2;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL short_ferr got=%b exp=1", frame_error); end
    if (got.size() - gb !== 1) begin errors++; $display("FAIL short_count got=%0d exp=1", got.size() - gb); end
    if (got.size() > gb) begin
      checks++;
      if (got[gb] !== exp_q[0]) begin errors++; $display("FAIL short_sample got=%h exp=%h", got[gb], exp_q[0]); end
    end
    pulse_clear();
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL short_clear got=%b exp=0", frame_error); end
  endtask

  task automatic test_enable();
    logic [15:0] d;
    begin_test(1'b0);
    d = 16'($urandom);
    send_slot(1'b0, d, 32, 0, -1, 1'b0); model_push(1'b1, d, 0);
    send_slot(1'b1, 16'($urandom), 32, 0, 8, 1'b0);
    checks++;
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL en_kept got=%b exp=1", sample_valid); end
    drain();
    checks++;
    if (got.size() - gb !== 1) begin errors++; $display("FAIL en_off_count got=%0d exp=1", got.size() - gb); end
    hold = 1'b1;
    send_slot(1'b0, 16'($urandom), 32, 0, 10, 1'b1);
    for (int k = 1; k < 4; k++) begin
      d = 16'($urandom);
      send_slot(k[0], d, 32, 0, -1, 1'b0);
      model_push(!k[0], d, 0);
    end
    drain();
    checks++;
    if (got.size() - gb !== exp_q.size()) begin
      errors++; $display("FAIL en_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL en_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] d;
    begin_test(1'b1);
    for (int k = 0; k < 8; k++) begin
      d = 16'($urandom);
      send_slot(k[0], d, 32, 0, -1, 1'b0);
      model_push(!k[0], d, 0);
    end
    #1 sample_ready = 1'b0;
    checks++;
    if (got.size() - gb !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    begin_test(1'b0);
    for (int k = 0; k < 4; k++) begin
      d = 16'($urandom);
      send_slot(k[0], d, 32, 0, -1, 1'b0);
      model_push(!k[0], d, 0);
    end
    d = 16'($urandom);
    send_slot(1'b0, d, 32, 2, -1, 1'b0); model_push(1'b1, d, 1);
    checks += 3;
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", sample_valid); end
    if (got.size() - gb !== 1) begin errors++; $display("FAIL b2b_popped got=%0d exp=1", got.size() - gb); end
    drain();
    checks++;
    if (got.size() - gb !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    begin_test(1'b0);
    send_slot(1'b1, 16'($urandom), 32, 0, -1, 1'b0);
    send_slot(1'b0, 16'($urandom), 32, 0, -1, 1'b0);
    send_slot(1'b1, 16'($urandom), 6, 0, -1, 1'b0);
    send_slot(1'b0, 16'($urandom), 8, 0, -1, 1'b0);
    checks += 2;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL rst_pre_ferr got=%b exp=1", frame_error); end
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", sample_valid); end
    #3 reset_n = 1'b0;
    #1 checks += 4;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b exp=0", frame_error); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    if (sample_data !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", sample_data); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    prime();
    begin_test(1'b1);
    for (int k = 0; k < 2; k++) begin
      d = 16'($urandom);
      send_slot(k[0], d, 32, 0, -1, 1'b0);
      model_push(!k[0], d, 0);
    end
    #1 sample_ready = 1'b0;
    checks++;
    if (got.size() - gb !== exp_q.size()) begin
      errors++; $display("FAIL rst_after_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) if (gb + i < got.size()) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_after_sample%0d got=%h exp=%h", i, got[gb+i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear_status = 1'b0; sample_ready = 1'b0;
    adc_bclk = 1'b0; adc_lrck = 1'b0; adc_dat = 1'b0;
    hold = 1'b0; held = 0; exp_ovf = 1'b0; gb = 0;
    test_reset();
    test_latency();
    test_basic();
    test_overflow();
    test_short_frame();
    test_enable();
    test_random_stream();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
